riscv_mem_responder: RTL and testbench



---
 rtl/riscv_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_riscv_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_responder.sv
// Wait-state memory responder for the core's load/store port: word reads, byte-enabled writes.
// Define RISCV_MEM_RESP_ERR_EN to reject misaligned/out-of-range accesses and report them on err.
//
// state  | meaning
// S_IDLE | waiting for req; captures the request on the accepting edge
// S_WAIT | counting down wait states before completing an accepted access
// S_RESP | ack (and err) high for exactly one cycle
module riscv_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic             capture;
  logic             commit;
  logic             acc_we;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic             mem_we;
  logic             rd_en;

  logic [29:0]      word_off;
  logic [IDX_W-1:0] in_idx;
  logic             in_rej;

  logic [31:0]      mem [DEPTH_WORDS];

  // Word offset from the base; addresses below the base wrap to a large offset.
  assign word_off = addr[31:2] - BASE_ADDR[31:2];
  assign in_idx   = IDX_W'(word_off % 30'(DEPTH_WORDS));

`ifdef RISCV_MEM_RESP_ERR_EN
  assign in_rej = (addr[1:0] != 2'b00) || (word_off >= 30'(DEPTH_WORDS));
`else
  logic unused_addr_lsb;
  assign in_rej          = 1'b0;
  assign unused_addr_lsb = ^addr[1:0];
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    commit     = 1'b0;
    acc_we     = we_q;
    acc_idx    = idx_q;
    acc_wdata  = wdata_q;
    acc_be     = be_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          capture   = 1'b1;
          acc_we    = we;
          acc_idx   = in_idx;
          acc_wdata = wdata;
          acc_be    = be;
          if (in_rej) begin
            state_next = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            commit     = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_next = S_RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A reset coinciding with the committing edge must not write the array.
  assign mem_we = commit & acc_we & ~rst;
  assign rd_en  = commit & ~acc_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 32'h0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ack   <= (state_next == S_RESP);
      busy  <= (state_next != S_IDLE);
      if (capture) begin
        we_q    <= we;
        idx_q   <= in_idx;
        wdata_q <= wdata;
        be_q    <= be;
      end
      if (rd_en) begin
        rdata <= mem[acc_idx];
      end
    end
  end

`ifdef RISCV_MEM_RESP_ERR_EN
  // Only a rejected capture goes straight from IDLE to RESP with err set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= capture & in_rej;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Array contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: directed scenarios plus randomized
// accesses checked against a word-array reference model.
module tb_riscv_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 256;
  localparam int          WAITC = 2;
  localparam int          P     = WAITC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  riscv_mem_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .be   (be),
    .rdata(rdata),
    .ack  (ack),
    .err  (err),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_rej(input logic [31:0] a);
`ifdef RISCV_MEM_RESP_ERR_EN
    return (a[1:0] != 2'b00) || (((a - BASE) >> 2) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % DEPTH);
  endfunction

  // One complete transaction: request, latency/handshake checks, model update.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input string tag);
    bit rej;
    int idx;
    int n;
    int exp_lat;
    rej     = is_rej(a);
    idx     = widx(a);
    exp_lat = rej ? 1 : WAITC + 1;
    if (!rej) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        ref_rdata = ref_mem[idx];
      end
    end
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    n = 1;
    while (ack !== 1'b1 && n <= WAITC + 4) begin
      chk({tag, "_busy_wait"}, busy, 1);
      chk({tag, "_err_wait"}, err, 0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_ack"}, ack, 1);
    chk({tag, "_err"}, err, rej);
    chk({tag, "_rdata"}, rdata, ref_rdata);
    chk({tag, "_busy_resp"}, busy, 1);
    @(negedge clk);
    chk({tag, "_ack_after"}, ack, 0);
    chk({tag, "_err_after"}, err, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int n;
    int acks;
    int pulses;
    int last;
    logic [31:0] a;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    ref_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_full");
    access(1'b0, 32'h10, 32'h0, 4'h0, "rd_full");
    chk("rd_full_value", rdata, 32'hDEADBEEF);
    repeat (5) @(negedge clk);
    chk("rdata_hold", rdata, 32'hDEADBEEF);

    access(1'b1, 32'h10, 32'h11223344, 4'b0101, "wr_part");
    access(1'b0, 32'h10, 32'h0, 4'hF, "rd_part");
    chk("part_value", rdata, 32'hDE22BE44);

    // req held high across three reads
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
    @(posedge clk);
    pulses = 0;
    last = -1;
    for (int k = 1; k <= 5 * P; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        pulses++;
        if (last >= 0) chk("hold_spacing", k - last, P);
        else chk("hold_first", k, WAITC + 1);
        chk("hold_rdata", rdata, ref_mem[4]);
        last = k;
      end
      if (k == 3 * P) req = 1'b0;
    end
    chk("hold_pulses", pulses, 3);
    ref_rdata = ref_mem[4];

`ifdef RISCV_MEM_RESP_ERR_EN
    access(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, "rej_misal");
    access(1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, "rej_range");
    access(1'b0, 32'h13, 32'h0, 4'h0, "rej_read");
    access(1'b0, 32'h10, 32'h0, 4'h0, "rd_after_rej");
    chk("rej_unchanged", rdata, 32'hDE22BE44);
`else
    access(1'b1, 32'(4 * DEPTH) + 32'h14, 32'hCAFE_F00D, 4'hF, "wr_alias");
    access(1'b0, 32'h17, 32'h0, 4'h0, "rd_alias");
    chk("alias_value", rdata, 32'hCAFE_F00D);
`endif

    // reset while in WAIT aborts a pending write
    access(1'b1, 32'h20, 32'h5566_7788, 4'hF, "wr_pre");
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0000_00AA; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("abort_busy_e0", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = 32'h0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_idle", busy, 0);
    access(1'b0, 32'h20, 32'h0, 4'h0, "rd_abort");
    chk("abort_value", rdata, 32'h5566_7788);

    // reset coincident with the capturing edge
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack === 1'b1 || busy === 1'b1) acks++;
    end
    chk("rstcap_no_activity", acks, 0);
    access(1'b0, 32'h20, 32'h0, 4'h0, "rd_rstcap");

    // reset in RESP: ack drops at once, committed write survives
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h0BAD_F00D; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n = 1;
    while (ack !== 1'b1 && n <= WAITC + 4) begin
      @(negedge clk);
      n++;
    end
    chk("resp_rst_latency", n, WAITC + 1);
    rst = 1'b1;
    #1;
    chk("resp_rst_ack", ack, 0);
    chk("resp_rst_err", err, 0);
    chk("resp_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[12] = 32'h0BAD_F00D;
    ref_rdata = 32'h0;
    chk("resp_rst_rdata", rdata, 32'h0);
    access(1'b0, 32'h30, 32'h0, 4'h0, "rd_resp_rst");

    // randomized traffic over a small known window
    for (int i = 0; i < 16; i++) access(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, "rnd_init");
    for (int t = 0; t < 60; t++) begin
      a = BASE + 32'(4 * $urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = a + 32'(4 * DEPTH);
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
